// File: rtl/div_unit.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) with start/busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC/FIX.
module div_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [5:0]            r_cnt;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [XLEN-1:0]       r_dvsr;
  logic [XLEN-1:0]       r_specVal;
  logic [XLEN-1:0]       r_result;
  logic                  r_isRem;
  logic                  r_negQ;
  logic                  r_negR;
  logic                  r_special;
  logic [REG_ADDR_W-1:0] r_rdLatch;
  logic [REG_ADDR_W-1:0] r_rdOut;

  logic                  w_accept;
  logic                  w_signedOp;
  logic                  w_aNeg;
  logic                  w_bNeg;
  logic [XLEN-1:0]       w_aMag;
  logic [XLEN-1:0]       w_bMag;
  logic                  w_divZero;
  logic                  w_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_specVal;
  logic                  w_lastIter;
  logic [XLEN:0]         w_trial;
  logic [XLEN:0]         w_diff;
  logic [XLEN-1:0]       w_quoFix;
  logic [XLEN-1:0]       w_remFix;
  logic [XLEN-1:0]       w_fixResult;

  assign w_accept   = (r_state == IDLE) && start && !flush;
  assign w_signedOp = ~op[0];
  assign w_aNeg     = w_signedOp & rs1_data[XLEN-1];
  assign w_bNeg     = w_signedOp & rs2_data[XLEN-1];
  assign w_aMag     = w_aNeg ? (~rs1_data + 1'b1) : rs1_data;
  assign w_bMag     = w_bNeg ? (~rs2_data + 1'b1) : rs2_data;
  assign w_divZero  = (rs2_data == '0);
  assign w_ovf      = w_signedOp && (rs1_data == MinNeg) && (rs2_data == '1);
  assign w_special  = w_divZero | w_ovf;
  assign w_specVal  = w_divZero ? (op[1] ? rs1_data : '1)
                                : (op[1] ? '0 : MinNeg);
  assign w_lastIter = (r_cnt == 6'(XLEN-1));

  // A negative trial difference shows up in the extra top bit.
  assign w_trial    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_trial - {1'b0, r_dvsr};

  assign w_quoFix    = r_negQ ? (~r_quo + 1'b1) : r_quo;
  assign w_remFix    = r_negR ? (~r_rem + 1'b1) : r_rem;
  assign w_fixResult = r_isRem ? w_remFix : w_quoFix;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = (EarlyOut && w_special) ? DONE : CALC;
        CALC:    if (w_lastIter) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  assign result = r_result;
  assign rd_out = r_rdOut;

  // Operand capture, iteration and result/rd commit; rd_out only moves with result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_specVal <= '0;
      r_result  <= '0;
      r_isRem   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_special <= 1'b0;
      r_rdLatch <= '0;
      r_rdOut   <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_aMag;
      r_dvsr    <= w_bMag;
      r_specVal <= w_specVal;
      r_isRem   <= op[1];
      r_negQ    <= w_aNeg ^ w_bNeg;
      r_negR    <= w_aNeg;
      r_special <= w_special;
      r_rdLatch <= rd_in;
      if (EarlyOut && w_special) begin
        r_result <= w_specVal;
        r_rdOut  <= rd_in;
      end
    end else if (!flush) begin
      if (r_state == CALC) begin
        r_cnt <= r_cnt + 6'd1;
        if (!w_diff[XLEN]) begin
          r_rem <= w_diff[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b1};
        end else begin
          r_rem <= w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b0};
        end
      end else if (r_state == FIX) begin
        r_result <= r_special ? r_specVal : w_fixResult;
        r_rdOut  <= r_rdLatch;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed test-plan cases, abort paths and a few random ops.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [4:0]  rdIn;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [7:0]  lat;
  } exp_t;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SpecialLat = 1;
`else
  localparam int SpecialLat = 34;
`endif

  div_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1Data), .rs2_data(rs2Data), .rd_in(rdIn), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rdOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference from the RV32M definition, not from the iteration.
  function automatic logic [31:0] refDiv(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Called at a falling edge; start is accepted at the next rising edge (cycle 0).
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes,
                               input int expLat, input bit doPush);
    exp_t e;
    op = o; rs1Data = a; rs2Data = b; rdIn = rd; start = 1'b1;
    if (doPush) begin
      e.res = expRes; e.rd = rd; e.lat = 8'(expLat);
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the cycle-1 sample point; waits (bounded) for done and scores it.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    if (sbQ.size() == 0) begin
      check({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " result"}, result, e.res);
      check({tag, " rd_out"}, 32'(rdOut), 32'(e.rd));
    end
    @(negedge clk);
    check({tag, " single done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          doneCount;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e;

    rst = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; rs1Data = '0; rs2Data = '0; rdIn = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rdOut), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34, 1);
    checkOutput("divu 100/7");
    applyStimulus(2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 34, 1);
    checkOutput("remu 100/7");
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, 1);
    checkOutput("div -7/2");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34, 1);
    checkOutput("rem -7/2");
    applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 34, 1);
    checkOutput("div 7/-2");
    applyStimulus(2'b00, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, SpecialLat, 1);
    checkOutput("div 5/0");
    applyStimulus(2'b11, 32'd5, 32'd0, 5'd12, 32'd5, SpecialLat, 1);
    checkOutput("remu 5/0");
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, SpecialLat, 1);
    checkOutput("div overflow");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, SpecialLat, 1);
    checkOutput("rem overflow");

    // Extra starts in cycles 10 and 34 must be dropped, not queued.
    applyStimulus(2'b01, 32'd1000, 32'd10, 5'd3, 32'd100, 34, 1);
    doneCount = 0;
    for (int lat = 1; lat <= 45; lat++) begin
      if (done) begin
        doneCount++;
        check("ignored-start latency", 32'(lat), 32'd34);
        check("ignored-start result", result, 32'd100);
        check("ignored-start rd_out", 32'(rdOut), 32'd3);
        if (sbQ.size() != 0) e = sbQ.pop_front();
      end
      start = (lat == 10) || (lat == 34);
      if (start) begin
        op = 2'b01; rs1Data = 32'd7; rs2Data = 32'd1; rdIn = 5'd17;
      end
      @(negedge clk);
    end
    check("ignored-start done count", 32'(doneCount), 32'd1);
    check("ignored-start busy after", 32'(busy), 32'd0);
    check("ignored-start result held", result, 32'd100);

    // Reset asserted in cycle 15 of CALC.
    applyStimulus(2'b01, 32'd12345, 32'd3, 5'd6, 32'd0, 0, 0);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid-calc reset busy", 32'(busy), 32'd0);
    check("mid-calc reset result", result, 32'd0);
    check("mid-calc reset rd_out", 32'(rdOut), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    check("mid-calc reset no done", 32'(doneCount), 32'd0);

    // Flush in cycle 20 keeps the previous result and rd_out.
    applyStimulus(2'b11, 32'd100, 32'd7, 5'd9, 32'd2, 34, 1);
    checkOutput("remu before flush");
    applyStimulus(2'b01, 32'd50, 32'd5, 5'd4, 32'd0, 0, 0);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    check("flush no done", 32'(doneCount), 32'd0);
    check("flush result held", result, 32'd2);
    check("flush rd_out held", 32'(rdOut), 32'd9);

    // Flush and start together in IDLE: start loses.
    op = 2'b00; rs1Data = 32'd5; rs2Data = 32'd0; rdIn = 5'd21;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", 32'(busy), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    check("flush+start no done", 32'(doneCount), 32'd0);
    check("flush+start result held", result, 32'd2);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i % 4);
      ra = $urandom;
      rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) rb = 32'hFFFF_FFF3;
      applyStimulus(ro, ra, rb, 5'(i + 1), refDiv(ro, ra, rb),
                    isSpecial(ro, ra, rb) ? SpecialLat : 34, 1);
      checkOutput($sformatf("random op%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits between the register file read ports and the writeback path:
- It consumes the rs1/rs2 operand values and the destination register index.
- It produces a result and a one-cycle `done` pulse that writeback uses as `reg_write` for `rd_out`.
- It uses a radix-2 restoring algorithm, one quotient bit per cycle, with a start/busy/done handshake so the core can stall while a divide is in flight.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported for RV32.
- `REG_ADDR_W`, default 5: destination register index width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-low reset. Sampled on rising `clk`. Highest priority.
- `start` in 1: request. Accepted only when `busy`=0 and `flush`=0.
- `op` in 2: operation. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data` in XLEN: dividend.
- `rs2_data` in XLEN: divisor.
- `rd_in` in REG_ADDR_W: destination index, captured on accept.
- `flush` in 1: synchronous abort of any in-flight operation.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse. `result` and `rd_out` are valid in that cycle.
- `result` out XLEN: quotient or remainder. Held until the next accepted `start`.
- `rd_out` out REG_ADDR_W: captured `rd_in`, held with `result`.

## Operation
- States:
  - IDLE: wait for an accepted `start`.
  - CALC: XLEN iterations.
  - FIX: sign correction and result select.
  - DONE: one cycle.
- Transitions:
  - IDLE→CALC on an accepted `start`.
  - In CALC, a 6-bit counter runs 0..XLEN-1. CALC→FIX when the counter reaches XLEN-1.
  - FIX→DONE.
  - DONE→IDLE unconditionally.
- On accept, the unit latches `op` and `rd_in`, and latches the magnitudes of the operands:
  - Signed ops (DIV, REM) use the absolute value of each operand.
  - Unsigned ops use the raw value.
- Each CALC cycle shifts {rem, quo} left by 1 and trial-subtracts the divisor using an (XLEN+1)-bit difference:
  - Non-negative difference: rem is replaced by the difference and the quotient LSB is set to 1.
  - Negative difference: rem is restored and the quotient LSB is 0.
- Sign rules in FIX, for signed ops:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases are detected at accept and override the FIX output:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF. REM/REMU give the dividend unchanged.
  - Signed overflow (DIV with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- `start` while `busy`=1, including during DONE, is ignored. It is not queued.
- `flush`=1 in any state goes to IDLE next cycle:
  - No `done` is produced.
  - `result` and `rd_out` keep their previous values.
  - `flush` and `start` in the same IDLE cycle: `start` is ignored.
- `rst`=0 at an edge, in any state and including mid-CALC:
  - State goes to IDLE and the counter is cleared.
  - Outputs after reset: `busy`=0, `done`=0, `result`=0, `rd_out`=0.

## Timing
- Cycle 0 is the cycle in which `start` is accepted.
- Normal path:
  - CALC occupies cycles 1..XLEN.
  - FIX occupies cycle XLEN+1.
  - `done`=1 in cycle XLEN+2, which is cycle 34 for XLEN=32.
- `busy`=1 from cycle 1 through the DONE cycle inclusive.
- The earliest next accept is the cycle after DONE, giving a throughput of one operation per XLEN+3 cycles.
- `done` is registered. It is never high for two consecutive cycles.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed-overflow cases take IDLE→DONE directly, skipping CALC and FIX.
  - `done`=1 in cycle 1, with `busy`=1 only in cycle 1.
- `DIV_EARLY_OUT_EN` undefined:
  - Special cases follow the normal path and finish in cycle XLEN+2.
  - Results are identical to the defined case. Only the latency differs.

## Test plan
- DIVU 100 / 7 with `rd_in`=5: `done` in cycle 34 with `result`=14 and `rd_out`=5. REMU with the same operands gives 2.
- DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD (-3). REM with the same operands gives 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE gives 0xFFFFFFFD.
- DIV 5 / 0 gives 0xFFFFFFFF and REMU 5 / 0 gives 5. `done` is in cycle 1 with `DIV_EARLY_OUT_EN` defined and cycle 34 without.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0.
- Second `start` pulsed in cycles 10 and 34 of an active operation: both are ignored, the first result is unchanged, and exactly one `done` pulse occurs.
- `rst`=0 in cycle 15 of CALC: `busy`=0 and `result`=0 the next cycle, and no `done`. Separately, `flush` in cycle 20: no `done`, and the prior `result` is held.
